// File: rtl/mem_fetch_ctrl.sv
// Window fetch controller: streams cnt_len pixels of one image row-window from BRAM into a line buffer.
// Define BRAM_REG_OUT_EN when the BRAM output register is enabled (read latency 2 instead of 1).
module mem_fetch_ctrl #(
  parameter int MAX_ROW = 540,
  parameter int MAX_COL = 540,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_run_i,
  input  logic [19:0]       cnt_len_i,
  output logic              fetch_done_o,
  output logic [9:0]        cnt_img_row_o,
  output logic              bram_en_o,
  output logic [18:0]       bram_addr_o,
  input  logic [DATA_W-1:0] bram_rdata_i,
  output logic              buf_wr_en_o,
  output logic [10:0]       buf_wr_addr_o,
  output logic [DATA_W-1:0] buf_wr_data_o
);

`ifdef BRAM_REG_OUT_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif

  localparam int          MAX_LEN   = 2048;
  localparam logic [18:0] ADDR_MAX  = 19'(MAX_ROW * MAX_COL - 1);
  localparam logic [9:0]  ROW_WRAP  = 10'(MAX_ROW - 3);
  localparam logic [L-1:0] LAST_ONLY = L'(1 << (L - 1));

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

  state_e      state_q;
  logic        first_q;
  logic [9:0]  row_q;
  logic [11:0] len_q;
  logic [10:0] k_q;
  logic        en_q;
  logic [18:0] addr_q;
  logic        done_q;
  logic [L-1:0] vld_q;
  logic [10:0] kdly_q [L];

  logic [9:0]  row_d;
  logic [11:0] len_d;

  function automatic logic [11:0] sat_len(input logic [19:0] len);
    return (len > 20'(MAX_LEN)) ? 12'(MAX_LEN) : len[11:0];
  endfunction

  function automatic logic [18:0] clamp_addr(input logic [9:0] row, input logic [10:0] k);
    logic [19:0] a;
    a = 20'(row) * 20'(MAX_COL) + 20'(k);
    return (a > 20'(ADDR_MAX)) ? ADDR_MAX : 19'(a);
  endfunction

  // The very first fetch after reset stays on row 0; later ones advance and wrap.
  always_comb begin
    row_d = row_q;
    if (!first_q) row_d = (row_q == ROW_WRAP) ? 10'd0 : row_q + 10'd1;
    len_d = sat_len(cnt_len_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      first_q <= 1'b1;
      row_q   <= '0;
      len_q   <= '0;
      k_q     <= '0;
      en_q    <= 1'b0;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fetch_run_i) begin
            first_q <= 1'b0;
            row_q   <= row_d;
            len_q   <= len_d;
            k_q     <= '0;
            addr_q  <= clamp_addr(row_d, 11'd0);
            if (len_d == 12'd0) begin
              state_q <= DONE;
            end else begin
              en_q    <= 1'b1;
              state_q <= READ;
            end
          end
        end
        READ: begin
          if (12'(k_q) == len_q - 12'd1) begin
            en_q    <= 1'b0;
            state_q <= DRAIN;
          end else begin
            k_q    <= k_q + 11'd1;
            addr_q <= clamp_addr(row_q, k_q + 11'd1);
          end
        end
        // Leave once only the final write remains in flight.
        DRAIN: if (vld_q == LAST_ONLY) state_q <= DONE;
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read-latency delay line: enable and buffer index travel with the BRAM data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < L; i++) kdly_q[i] <= '0;
    end else begin
      vld_q[0]  <= en_q;
      kdly_q[0] <= k_q;
      for (int i = 1; i < L; i++) begin
        vld_q[i]  <= vld_q[i-1];
        kdly_q[i] <= kdly_q[i-1];
      end
    end
  end

  assign fetch_done_o  = done_q;
  assign cnt_img_row_o = row_q;
  assign bram_en_o     = en_q;
  assign bram_addr_o   = addr_q;
  assign buf_wr_en_o   = vld_q[L-1];
  assign buf_wr_addr_o = kdly_q[L-1];
  assign buf_wr_data_o = vld_q[L-1] ? bram_rdata_i : '0;

endmodule

// File: tb/tb_mem_fetch_ctrl.sv
// Directed bench for mem_fetch_ctrl with a behavioural BRAM holding an address-derived pattern.
module tb_mem_fetch_ctrl;

`ifdef BRAM_REG_OUT_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif
  localparam int MAX_ROW = 540;
  localparam int MAX_COL = 540;
  localparam int DATA_W  = 8;
  localparam int AMAX    = MAX_ROW * MAX_COL - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              fetch_run = 1'b0;
  logic [19:0]       cnt_len = '0;
  logic              fetch_done;
  logic [9:0]        img_row;
  logic              bram_en;
  logic [18:0]       bram_addr;
  logic [DATA_W-1:0] bram_rdata;
  logic              wr_en;
  logic [10:0]       wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] r1 = '0, r2 = '0;

  int nvec = 0;
  int nerr = 0;

  mem_fetch_ctrl #(.MAX_ROW(MAX_ROW), .MAX_COL(MAX_COL), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_run_i(fetch_run), .cnt_len_i(cnt_len),
    .fetch_done_o(fetch_done), .cnt_img_row_o(img_row), .bram_en_o(bram_en),
    .bram_addr_o(bram_addr), .bram_rdata_i(bram_rdata), .buf_wr_en_o(wr_en),
    .buf_wr_addr_o(wr_addr), .buf_wr_data_o(wr_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input int a);
    logic [31:0] v;
    v = 32'(a);
    return v[7:0] ^ v[15:8] ^ 8'hA5;
  endfunction

  function automatic int exp_addr(input int row, input int k);
    int a;
    a = row * MAX_COL + k;
    return (a > AMAX) ? AMAX : a;
  endfunction

  always @(posedge clk) begin
    if (bram_en) r1 <= pat(int'(bram_addr));
    r2 <= r1;
  end
  assign bram_rdata = (L == 2) ? r2 : r1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One complete fetch; cycle j is observed on the falling edge after the j-th rising edge past the start.
  task automatic do_fetch(input int len_in, input int exp_row, input string tag);
    int n, en_bad, wr_bad, row_bad, en_cnt, wr_cnt, done_at, extra_done, exp_done;
    n = (len_in > 2048) ? 2048 : len_in;
    exp_done = (n == 0) ? 1 : n + L + 1;
    en_bad = 0; wr_bad = 0; row_bad = 0; en_cnt = 0; wr_cnt = 0; done_at = -1; extra_done = 0;
    @(negedge clk);
    fetch_run = 1'b1;
    cnt_len = 20'(len_in);
    @(posedge clk);
    #1;
    fetch_run = 1'b0;
    cnt_len = 20'd77;
    for (int j = 0; j < n + L + 8; j++) begin
      @(negedge clk);
      if (j == 2 && n >= 10) begin
        fetch_run = 1'b1;
        cnt_len = 20'd3;
      end else begin
        fetch_run = 1'b0;
      end
      if (img_row !== 10'(exp_row)) row_bad++;
      if (bram_en === 1'b1) en_cnt++;
      if (j < n) begin
        if (bram_en !== 1'b1 || bram_addr !== 19'(exp_addr(exp_row, j))) en_bad++;
      end else if (bram_en !== 1'b0) en_bad++;
      if (wr_en === 1'b1) wr_cnt++;
      if (j >= L && j < n + L) begin
        if (wr_en !== 1'b1 || wr_addr !== 11'(j - L) ||
            wr_data !== pat(exp_addr(exp_row, j - L))) wr_bad++;
      end else if (wr_en !== 1'b0) wr_bad++;
      if (fetch_done === 1'b1) begin
        if (done_at < 0) done_at = j;
        else extra_done++;
      end
    end
    chk({tag, ".row"}, 32'(row_bad), 32'd0);
    chk({tag, ".rd_seq"}, 32'(en_bad), 32'd0);
    chk({tag, ".rd_cnt"}, 32'(en_cnt), 32'(n));
    chk({tag, ".wr_seq"}, 32'(wr_bad), 32'd0);
    chk({tag, ".wr_cnt"}, 32'(wr_cnt), 32'(n));
    chk({tag, ".done_at"}, 32'(done_at), 32'(exp_done));
    chk({tag, ".done_extra"}, 32'(extra_done), 32'd0);
  endtask

  initial begin
    int dcnt, en_seen, bad;

    // Reset state, observed without relying on a clock edge
    #3;
    chk("rst.en", 32'(bram_en), 0);
    chk("rst.wr_en", 32'(wr_en), 0);
    chk("rst.done", 32'(fetch_done), 0);
    chk("rst.row", 32'(img_row), 0);
    chk("rst.addr", 32'(bram_addr), 0);
    chk("rst.wr_addr", 32'(wr_addr), 0);
    chk("rst.wr_data", 32'(wr_data), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    do_fetch(1620, 0, "f1620_r0");
    do_fetch(1620, 1, "f1620_r1");
    do_fetch(0, 2, "len0");
    do_fetch(3000, 3, "len3000");
    do_fetch(5, 4, "len5");

    // Held request with zero length: a new fetch starts in every IDLE cycle after DONE
    dcnt = 0; en_seen = 0;
    @(negedge clk);
    fetch_run = 1'b1;
    cnt_len = '0;
    for (int j = 0; j < 2 * 532 + 20 && dcnt < 532; j++) begin
      @(negedge clk);
      if (bram_en === 1'b1 || wr_en === 1'b1) en_seen++;
      if (fetch_done === 1'b1) dcnt++;
      if (dcnt == 532) fetch_run = 1'b0;
    end
    fetch_run = 1'b0;
    chk("b2b.done_cnt", 32'(dcnt), 32'd532);
    chk("b2b.no_bram", 32'(en_seen), 32'd0);
    chk("b2b.row", 32'(img_row), 32'd536);

    do_fetch(2048, 537, "clamp_r537");
    do_fetch(3, 0, "wrap_r0");

    // Reset in the middle of a fetch
    @(negedge clk);
    fetch_run = 1'b1;
    cnt_len = 20'd1620;
    @(posedge clk);
    #1;
    fetch_run = 1'b0;
    for (int j = 0; j < 700; j++) @(negedge clk);
    chk("mid.en_before", 32'(bram_en), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid.en", 32'(bram_en), 0);
    chk("mid.wr_en", 32'(wr_en), 0);
    chk("mid.addr", 32'(bram_addr), 0);
    chk("mid.wr_addr", 32'(wr_addr), 0);
    chk("mid.wr_data", 32'(wr_data), 0);
    chk("mid.row", 32'(img_row), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (fetch_done !== 1'b0 || bram_en !== 1'b0 || wr_en !== 1'b0) bad++;
    end
    chk("mid.quiet", 32'(bad), 0);
    do_fetch(4, 0, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
